// File: rtl/mul16_seq_pkg.sv
// mul16_seq shared definitions
// Width, step count and FSM encodings
package mul16_seq_pkg;

  localparam int MUL_W     = 16;
  localparam int MUL_STEPS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// Add16: 16-bit combinational adder
// Carry out of bit 15 is discarded
module Add16
  import mul16_seq_pkg::*;
(
  input  logic [MUL_W-1:0] x,
  input  logic [MUL_W-1:0] y,
  output logic [MUL_W-1:0] sum
);

  assign sum = x + y;

endmodule

// File: rtl/mul16_seq.sv
// mul16_seq: shift-and-add multiplier
// One partial product per clock via Add16
module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic [MUL_W-1:0] product,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_n;
  logic [MUL_W-1:0] mcand;
  logic [MUL_W-1:0] mplier;
  logic [MUL_W-1:0] acc;
  logic [4:0]       cnt;
  logic [MUL_W-1:0] sum;
  logic [MUL_W-1:0] step_sum;
  logic             last;
  logic             accept;

  Add16 u_add (
    .x   (acc),
    .y   (mcand),
    .sum (sum)
  );

  // Partial product selected by current multiplier LSB
  always_comb begin
    step_sum = acc;
    if (mplier[0])
      step_sum = sum;
  end

  assign last   = (cnt == 5'(MUL_STEPS - 1));
  assign accept = start && (state != ST_RUN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  // Next state and status outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start)
          state_n = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last)
          state_n = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start)
          state_n = ST_RUN;
        else
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Operand latch, shift/accumulate steps, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      acc    <= step_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      if (last)
        product <= step_sum;
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: table vectors + scoreboard
// Hand sequences for multi-cycle corners
module tb_mul16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  mul16_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  // Drive start at negedge; returns #1 after the accept edge
  task automatic issue(input logic [15:0] ta,
                       input logic [15:0] tb,
                       input logic [15:0] exp);
    @(negedge clk);
    a     = ta;
    b     = tb;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after accept edge; waits for done, checks result
  task automatic wait_done(input string nm);
    int n;
    int bc;
    logic [15:0] e;
    n  = 0;
    bc = busy ? 1 : 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (busy) bc++;
    end
    chk({nm, "_done_seen"}, done, 1'b1);
    chk({nm, "_latency"}, n, 16);
    chk({nm, "_busy_cycles"}, bc, 16);
    chk({nm, "_busy_at_done"}, busy, 1'b0);
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_product"}, product, e);
    end
  endtask

  initial begin
    vec_t vt[4];
    int   dc;
    logic [15:0] held;

    checks = 0;
    errors = 0;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    vt[0] = '{16'hFFFF, 16'hFFFF, 16'h0001, "wrap"};
    vt[1] = '{16'h1234, 16'h9876, 16'h43F8, "mixed"};
    vt[2] = '{16'hFFFF, 16'h0007, 16'hFFF9, "neg"};
    vt[3] = '{16'h0000, 16'hABCD, 16'h0000, "zero"};

    rst_n = 1'b0;
    #12;
    chk("rst_product", product, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h0003, 16'h0005, 16'h000F);
    chk("basic_busy_rise", busy, 1'b1);
    wait_done("basic");
    @(posedge clk);
    #1;
    chk("basic_done_drop", done, 1'b0);

    for (int i = 0; i < 4; i++) begin
      held = product;
      issue(vt[i].a, vt[i].b, vt[i].exp);
      chk({vt[i].nm, "_hold_in_run"}, product, held);
      wait_done(vt[i].nm);
      @(posedge clk);
      #1;
      chk({vt[i].nm, "_done_drop"}, done, 1'b0);
    end

    // start ignored while running
    issue(16'h0002, 16'h0003, 16'h0006);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 16'h00FF;
    b     = 16'h00FF;
    repeat (3) @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dc++;
        if (exp_q.size() != 0)
          chk("ignore_product", product, exp_q.pop_front());
      end
    end
    chk("ignore_done_count", dc, 1);
    chk("ignore_sb_drained", exp_q.size(), 0);

    // back-to-back start in the DONE cycle
    issue(16'h0003, 16'h0005, 16'h000F);
    wait_done("b2b_first");
    a     = 16'h0010;
    b     = 16'h0010;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(16'h0100);
    #1;
    start = 1'b0;
    chk("b2b_busy_next", busy, 1'b1);
    chk("b2b_done_drop", done, 1'b0);
    wait_done("b2b_second");
    @(posedge clk);
    #1;

    // reset in the middle of RUN
    issue(16'h0003, 16'h0005, 16'h000F);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_product", product, 16'h0);
    void'(exp_q.pop_front());
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
      if (i == 3) rst_n = 1'b1;
    end
    chk("mid_no_done", dc, 0);
    issue(16'h0003, 16'h0005, 16'h000F);
    wait_done("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
